// File: rtl/led_pkg.sv
// Shared definitions for the LED event pulser family: FSM encoding and
// the helper that maps a logical "LED active" level onto the pin polarity.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } led_state_t;

    // Pin level for a logical LED state; active_low flips the sense.
    function automatic logic led_level(input logic active, input bit active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: asserts tick for one cycle every TICK_DIV clocks.
// Never restarted by the consumer, so the first tick after any event is early.
module led_tick_gen #(
    parameter int TICK_DIV = 60000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/led_event_pulser.sv
// Turns single-cycle event strobes into evenly spaced, human-visible LED
// pulses: events queue in a saturating counter and replay as ON window + OFF gap.
module led_event_pulser
    import led_pkg::*;
#(
    parameter int TICK_DIV   = 60000,
    parameter int ON_TICKS   = 20,
    parameter int OFF_TICKS  = 20,
    parameter int PEND_W     = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              event_in,
    input  logic              clear,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]   PH_ON    = PH_W'(ON_TICKS);
    localparam logic [PH_W-1:0]   PH_OFF   = PH_W'(OFF_TICKS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    localparam logic LED_ON  = led_level(1'b1, ACTIVE_LOW != 0);
    localparam logic LED_OFF = led_level(1'b0, ACTIVE_LOW != 0);

    led_state_t        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PEND_W-1:0] pend_d;
    logic              ovf_d;
    logic              led_d;
    logic              busy_d;
    logic              tick;
    logic              start;
    logic              take;
    logic              phase_last;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // An event seen this cycle counts toward "work available"; clear drops it.
    assign take       = !clear && ((pending != '0) || event_in);
    assign phase_last = tick && (phase_q == PH_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            led_out  <= LED_OFF;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            pending  <= pend_d;
            overflow <= ovf_d;
            led_out  <= led_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)       state_d = ON;
            ON:      if (phase_last) state_d = OFF;
            OFF:     if (phase_last) state_d = take ? ON : IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    start   = 1'b1;
                    phase_d = PH_ON;
                end
            end
            ON: begin
                if (tick) phase_d = phase_last ? PH_OFF : (phase_q - PH_W'(1));
            end
            OFF: begin
                if (phase_last) begin
                    if (take) begin
                        start   = 1'b1;
                        phase_d = PH_ON;
                    end else begin
                        phase_d = '0;
                    end
                end else if (tick) begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: phase_d = '0;
        endcase

        // An event and a start in the same cycle cancel out.
        pend_d = pending;
        ovf_d  = overflow;
        if (clear) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (event_in && !start) begin
            if (pending == PEND_MAX) ovf_d  = 1'b1;
            else                     pend_d = pending + PEND_W'(1);
        end else if (!event_in && start) begin
            pend_d = pending - PEND_W'(1);
        end

        led_d  = (state_d == ON) ? LED_ON : LED_OFF;
        busy_d = (state_d != IDLE) || (pend_d != '0);
    end

endmodule

// File: tb/tb_led_event_pulser.sv
// Directed and randomized bench for led_event_pulser, compared every cycle
// against a timestamp-based reference of the pulse schedule.
module tb_led_event_pulser;

    localparam int DIV  = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 1;
    localparam int PW   = 2;
    localparam int QMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          event_in = 1'b0;
    logic          clear = 1'b0;
    logic          led_out, busy, overflow;
    logic [PW-1:0] pending;
    logic          led_b, busy_b, overflow_b;
    logic [PW-1:0] pending_b;

    int checks = 0;
    int errors = 0;

    // Reference: mode 0 idle, 1 lit, 2 gap; phase end given as an absolute edge number.
    int m_mode = 0;
    int m_q = 0;
    int m_end = 0;
    bit m_ovf = 1'b0;
    int edge_no = 0;
    int rst_edge = 0;

    led_event_pulser #(
        .TICK_DIV(DIV), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .PEND_W(PW), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .event_in(event_in), .clear(clear),
        .led_out(led_out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    led_event_pulser #(
        .TICK_DIV(DIV), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .PEND_W(PW), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst(rst), .event_in(event_in), .clear(clear),
        .led_out(led_b), .busy(busy_b), .pending(pending_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    // Ticks land on edges rst_edge + k*DIV (k >= 1); return the n-th one after edge e.
    function automatic int nth_tick(input int e, input int n);
        int m0;
        m0 = (e - rst_edge) / DIV + 1;
        return rst_edge + (m0 + n - 1) * DIV;
    endfunction

    task automatic model_update(input logic ev, input logic clr, input logic r);
        int x;
        bit st;
        int qn;
        x = edge_no + 1;
        edge_no = x;
        if (r) begin
            m_mode = 0; m_q = 0; m_ovf = 1'b0; rst_edge = x;
            return;
        end
        st = 1'b0;
        if (m_mode == 0) begin
            if (!clr && (m_q != 0 || ev)) begin
                st = 1'b1; m_mode = 1; m_end = nth_tick(x, ONT);
            end
        end else if (m_mode == 1) begin
            if (x == m_end) begin
                m_mode = 2; m_end = nth_tick(x, OFFT);
            end
        end else begin
            if (x == m_end) begin
                if (!clr && (m_q + int'(ev)) > 0) begin
                    st = 1'b1; m_mode = 1; m_end = nth_tick(x, ONT);
                end else begin
                    m_mode = 0;
                end
            end
        end
        if (clr) begin
            m_q = 0; m_ovf = 1'b0;
        end else begin
            qn = m_q + int'(ev) - int'(st);
            if (qn > QMAX) begin
                m_q = QMAX; m_ovf = 1'b1;
            end else begin
                m_q = qn;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic step(input logic ev, input logic clr, input logic r);
        event_in = ev;
        clear    = clr;
        rst      = r;
        @(posedge clk);
        model_update(ev, clr, r);
        #1;
        check("led_out",  8'(led_out),  8'(m_mode == 1));
        check("led_al",   8'(led_b),    8'(m_mode != 1));
        check("busy",     8'(busy),     8'((m_mode != 0) || (m_q != 0)));
        check("pending",  8'(pending),  8'(m_q));
        check("overflow", 8'(overflow), 8'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit hit;
        logic ev_r, clr_r, rst_r;

        // Reset and quiet period
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst_led",     8'(led_out),  8'd0);
        check("rst_led_al",  8'(led_b),    8'd1);
        check("rst_busy",    8'(busy),     8'd0);
        check("rst_pending", 8'(pending),  8'd0);
        check("rst_ovf",     8'(overflow), 8'd0);
        idle(9);

        // Single event
        step(1'b1, 1'b0, 1'b0);
        check("single_on", 8'(led_out), 8'd1);
        check("single_al", 8'(led_b),   8'd0);
        idle(20);
        check("single_idle_busy", 8'(busy), 8'd0);

        // Three back-to-back events
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("burst_pend1", 8'(pending), 8'd1);
        step(1'b1, 1'b0, 1'b0);
        check("burst_pend2", 8'(pending), 8'd2);
        idle(40);
        check("burst_done", 8'(pending), 8'd0);

        // Saturation: one consumed, five more while lit
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check("sat_pending", 8'(pending),  8'd3);
        check("sat_ovf",     8'(overflow), 8'd1);
        idle(60);
        check("sat_ovf_sticky", 8'(overflow), 8'd1);
        step(1'b0, 1'b1, 1'b0);
        check("clear_ovf", 8'(overflow), 8'd0);
        idle(4);

        // Event coincident with gap expiry while one event is queued
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == 2 && edge_no + 1 == m_end) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 1'b0);
        end
        check("gap_expiry_reached", 8'(hit), 8'd1);
        step(1'b1, 1'b0, 1'b0);
        check("coincide_pending", 8'(pending), 8'd1);
        check("coincide_led",     8'(led_out), 8'd1);
        idle(40);

        // Reset in the middle of a lit window with two queued
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("midrst_led",     8'(led_out), 8'd0);
        check("midrst_pending", 8'(pending), 8'd0);
        check("midrst_busy",    8'(busy),    8'd0);
        idle(30);

        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 399) == 0);
            clr_r = ($urandom_range(0, 79) == 0);
            ev_r  = ($urandom_range(0, 4) == 0);
            step(ev_r, clr_r, rst_r);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
